arb_mux: RTL and testbench

Parametrised, registered N-channel multiplexer with valid/ready handshakes, the successor to the datapath's fixed 2:1 select muxes. It merges `N` producer channels of `WIDTH` bits onto one registered output, using either arbitration or an explicit select forced by the control unit. It sits between multi-source producers (e.g. write-back/result sources, memory request sources) and a single consumer, and it tags every output beat with the index of its source channel.

---
 rtl/arb_mux_pkg.sv | 24 ++
 rtl/arb_mux_rr_arbiter.sv | 33 +++
 rtl/arb_mux.sv | 87 ++++++++
 tb/tb_arb_mux.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
//=============================================================================
// arb_mux_pkg: shared limits and helpers for arb_mux and its arbiter.
// Revision: 1.0
//=============================================================================
`default_nettype none

package arb_mux_pkg;

   localparam int ARB_MUX_MAX_N = 16;
   localparam int ARB_MUX_IDXW  = $clog2(ARB_MUX_MAX_N);

   // Index of the set bit of a one-hot vector (0 when no bit is set).
   function automatic logic [ARB_MUX_IDXW-1:0] onehot_idx(input logic [ARB_MUX_MAX_N-1:0] v);
      logic [ARB_MUX_IDXW-1:0] idx;
      idx = '0;
      for (int i = 0; i < ARB_MUX_MAX_N; i++) begin
         if (v[i]) idx = idx | ARB_MUX_IDXW'(i);
      end
      return idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/arb_mux_rr_arbiter.sv
//=============================================================================
// rr_arbiter: combinational one-hot arbiter, priority starting at ptr and wrapping.
// Revision: 1.0
//=============================================================================
`default_nettype none

module rr_arbiter #(
   parameter  int N    = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    gnt
);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] first;

   // Lower half holds requests at or above ptr, upper half all requests, so the
   // lowest set bit of the double-width vector is the wrapped winner.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         mask[i] = (SELW'(i) >= ptr);
      end
      dbl   = {req, req & mask};
      first = dbl & (~dbl + (2*N)'(1));
      gnt   = first[N-1:0] | first[2*N-1:N];
   end

endmodule

`default_nettype wire

// File: rtl/arb_mux.sv
//=============================================================================
// arb_mux: registered N:1 valid/ready mux with arbitration or forced select.
// Define ARB_MUX_RR_EN for round-robin; otherwise fixed priority (lowest index).
// Revision: 1.0
//=============================================================================
`default_nettype none

module arb_mux
   import arb_mux_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   input  logic               sel_en,
   input  logic [SELW-1:0]    sel,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   input  logic               out_ready
);

   localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

   logic [N-1:0]     req;
   logic [N-1:0]     grant;
   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  win_idx;
   logic [WIDTH-1:0] win_data;
   logic             load_ok;
   logic             transfer;

   always_comb begin
      req = in_valid;
      if (sel_en) begin
         req = '0;
         if ({1'b0, sel} < N_EXT) req[sel] = in_valid[sel];
      end
   end

   rr_arbiter #(.N(N)) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (grant)
   );

   // rst_n gating keeps in_ready low while the output register is held in reset.
   assign load_ok  = ~out_valid | out_ready;
   assign in_ready = grant & {N{load_ok & rst_n}};
   assign transfer = |(in_valid & in_ready);
   assign win_idx  = SELW'(onehot_idx(ARB_MUX_MAX_N'(grant)));
   assign win_data = in_data[win_idx*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (transfer) begin
         out_valid <= 1'b1;
         out_data  <= win_data;
         out_sel   <= win_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ARB_MUX_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (transfer && !sel_en) begin
         ptr <= (win_idx == SELW'(N-1)) ? '0 : win_idx + SELW'(1);
      end
   end
`else
   assign ptr = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arb_mux.sv
//=============================================================================
// tb_arb_mux: scoreboard bench for arb_mux (N=4) plus an N=5 instance for select range.
// Revision: 1.0
//=============================================================================
`default_nettype none

module tb_arb_mux;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int SELW  = 2;
   localparam int N5    = 5;
   localparam int W5    = 16;
   localparam int S5    = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               sel_en;
   logic [SELW-1:0]    sel;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_sel;
   logic               out_ready;

   logic [N5-1:0]      v5;
   logic [N5*W5-1:0]   d5;
   logic [N5-1:0]      r5;
   logic               se5;
   logic [S5-1:0]      s5;
   logic               ov5;
   logic [W5-1:0]      od5;
   logic [S5-1:0]      os5;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SELW-1:0]  sel;
   } beat_t;

   beat_t q[$];
   beat_t exp_beat;
   int    total = 0;
   int    bad   = 0;
   int    seq[5];

   always #5 clk = ~clk;

   arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .sel_en    (sel_en),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   arb_mux #(.WIDTH(W5), .N(N5)) dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v5),
      .in_data   (d5),
      .in_ready  (r5),
      .sel_en    (se5),
      .sel       (s5),
      .out_valid (ov5),
      .out_data  (od5),
      .out_sel   (os5),
      .out_ready (1'b1)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input int ch);
      beat_t b;
      b.data = in_data[ch*WIDTH +: WIDTH];
      b.sel  = SELW'(ch);
      q.push_back(b);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every beat leaving the output register must match the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected actual sel=%0d data=%h required=none", out_sel, out_data);
         end else begin
            exp_beat = q.pop_front();
            if (out_data !== exp_beat.data || out_sel !== exp_beat.sel) begin
               bad++;
               $display("FAIL beat actual sel=%0d data=%h required sel=%0d data=%h",
                        out_sel, out_data, exp_beat.sel, exp_beat.data);
            end
         end
      end
   end

   initial begin
`ifdef ARB_MUX_RR_EN
      seq = '{0, 1, 2, 3, 0};
`else
      seq = '{0, 0, 0, 0, 0};
`endif
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      sel_en    = 1'b0;
      sel       = '0;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = 32'hC0DE_0000 + 32'(i);
      v5  = '1;
      se5 = 1'b1;
      s5  = 3'd5;
      for (int i = 0; i < N5; i++) d5[i*W5 +: W5] = 16'h1000 + 16'(i);
      d5[4*W5 +: W5] = 16'hBEEF;

      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_sel", 64'(out_sel), 64'd0);
      check("reset_out_data", 64'(out_data), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd0);
      check("reset_n5_in_ready", 64'(r5), 64'd0);

      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         check("stream_in_ready", 64'(in_ready), 64'(4'b0001 << seq[k]));
         check("n5_oor_in_ready", 64'(r5), 64'd0);
         push(seq[k]);
         step();
      end
      check("n5_oor_out_valid", 64'(ov5), 64'd0);
      s5 = 3'd7;
      #1;
      check("n5_sel7_in_ready", 64'(r5), 64'd0);
      s5 = 3'd4;
      #1;
      check("n5_sel4_in_ready", 64'(r5), 64'b10000);

      in_valid = '0;
      step();
      check("drain_out_valid", 64'(out_valid), 64'd0);
      check("n5_sel4_out_sel", 64'(os5), 64'd4);
      check("n5_sel4_out_data", 64'(od5), 64'hBEEF);

      out_ready = 1'b0;
      in_valid  = 4'b0100;
      #1;
      check("stall_pick_in_ready", 64'(in_ready), 64'b0100);
      push(2);
      step();
      in_valid = 4'b0010;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out_sel", 64'(out_sel), 64'd2);
         check("stall_out_data", 64'(out_data), 64'hC0DE_0002);
         if (i < 2) step();
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", 64'(in_ready), 64'b0010);
      push(1);
      step();
      check("release_out_valid", 64'(out_valid), 64'd1);
      check("release_out_sel", 64'(out_sel), 64'd1);
      in_valid = '0;
      step();
      check("idle_out_valid", 64'(out_valid), 64'd0);

      sel_en   = 1'b1;
      sel      = 2'd2;
      in_valid = 4'b0011;
      #1;
      check("forced_block_in_ready", 64'(in_ready), 64'd0);
      step();
      check("forced_no_xfer", 64'(out_valid), 64'd0);
      in_data[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
      in_valid = 4'b0111;
      #1;
      check("forced_in_ready", 64'(in_ready), 64'b0100);
      push(2);
      step();
      check("forced_out_data", 64'(out_data), 64'hDEAD_BEEF);
      check("forced_out_sel", 64'(out_sel), 64'd2);
      sel_en   = 1'b0;
      in_valid = 4'b1100;
      #1;
      check("ptr_hold_in_ready", 64'(in_ready), 64'b0100);
      push(2);
      step();

      out_ready = 1'b0;
      in_valid  = 4'b1111;
      step();
      check("held_out_valid", 64'(out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      check("async_out_valid", 64'(out_valid), 64'd0);
      check("async_out_data", 64'(out_data), 64'd0);
      check("async_in_ready", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("post_reset_in_ready", 64'(in_ready), 64'b0001);
      push(0);
      step();
      in_valid = '0;
      step();
      step();
      check("queue_drain", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
